acq_scheduler: RTL
==================

Name: acq_scheduler

Overview:
- Automatic acquisition sequencer; sits directly upstream of the acquisition unit.
- Replaces host-driven start/PRN inputs with a round-robin sweep over all PRNs.
- Keeps an active-PRN mask so satellites already handed to tracking are not re-searched.
- Throttles new searches against tracking slot capacity and the pending-init FIFO.

Parameters:
NUM_PRN, 32, number of PRN indices swept (PRN value = index 0..NUM_PRN-1)
PRN_WIDTH, 5, width of PRN fields; 2^PRN_WIDTH >= NUM_PRN
MAX_SLOTS, 4, maximum simultaneously active PRNs (tracking slot count)
ACK_TIMEOUT, 64, cycles to wait for in_progress after a start pulse
SWEEP_DELAY, 1024, idle cycles after a fruitless full sweep (optional feature only)

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
enable  in  1  sweep enable; when low, finish current search then idle
acq_in_progress  in  1  acquisition unit busy
acq_complete  in  1  one-cycle strobe, search finished
satellite_acquired  in  1  one-cycle strobe, valid with acq_complete, peak passed threshold
acq_prn  in  PRN_WIDTH  PRN of completed search
init_fifo_full  in  1  pending-init FIFO full
release_valid  in  1  one-cycle strobe, tracking dropped a PRN
release_prn  in  PRN_WIDTH  PRN being released
acq_start  out  1  one-cycle start strobe to acquisition unit
acq_start_prn  out  PRN_WIDTH  PRN for current/last search, stable from start until next start
busy  out  1  high in any state except IDLE
active_mask  out  NUM_PRN  bit i set = PRN i acquired and owned by tracking
active_count  out  PRN_WIDTH+1  popcount of active_mask
timeout_err  out  1  one-cycle strobe on ACK_TIMEOUT expiry

Behaviour:
- Reset: state IDLE, outputs all 0, scan pointer 0, timers 0. Reset mid-search abandons it and issues no further pulses.
- States: IDLE, SELECT, START, WAIT_ACK, WAIT_DONE (plus BACKOFF with option).
- IDLE -> SELECT when enable && active_count < MAX_SLOTS.
- SELECT evaluates one candidate per cycle at the scan pointer.
  - Pointer is active: advance pointer mod NUM_PRN, stay in SELECT.
  - Pointer is inactive and init_fifo_full=0: latch acq_start_prn=pointer, advance pointer, go to START.
  - Pointer is inactive and init_fifo_full=1: hold pointer, stay in SELECT.
  - enable low or active_count >= MAX_SLOTS: go to IDLE, pointer retained.
- START: acq_start=1 for exactly this cycle; go to WAIT_ACK, timer cleared.
- WAIT_ACK: acq_in_progress=1 -> WAIT_DONE. Timer reaching ACK_TIMEOUT-1 -> timeout_err pulse, go to SELECT.
- WAIT_DONE: on acq_complete -> SELECT if enable, else IDLE. acq_complete arriving the same cycle as in_progress in WAIT_ACK counts as done.
- Mask set: acq_complete && satellite_acquired && acq_prn==acq_start_prn sets active_mask[acq_prn]. Completions with a mismatched PRN are ignored.
- Mask clear: release_valid clears active_mask[release_prn]; releasing an inactive PRN is a no-op. Release is accepted in every state.
- Same-cycle set and release of the same PRN: release applied first, then set (bit ends 1). Different PRNs: both apply.
- active_count updates the cycle after the mask change. Mask, count and pointer wrap modulo NUM_PRN; release_prn >= NUM_PRN is ignored.
- Latency: SELECT on an inactive candidate -> acq_start 1 cycle later; worst-case search for a free PRN is NUM_PRN cycles.

Optional Feature:
- ACQ_SCHED_SWEEP_DELAY_EN defined:
  - Track whether any PRN was newly acquired since the pointer last wrapped from NUM_PRN-1 to 0.
  - On a wrap with none acquired, enter BACKOFF for SWEEP_DELAY cycles (busy=1, no starts), then return to SELECT.
  - Reset or enable low in BACKOFF -> IDLE.
- Undefined: no BACKOFF state; sweep repeats back-to-back.

Test Plan:
- Reset, enable=1, model answers each start with in_progress after 2 cycles and complete (not acquired) after 10 -> starts issued for PRN 0,1,2,...,31,0 in order, one pulse each.
- Model acquires PRN 3 and PRN 7 -> active_mask=0x00000088, active_count=2; next sweep skips 3 and 7.
- MAX_SLOTS=4, acquire PRN 0..3 -> after the 4th completion busy=0 and no acq_start; release_valid PRN 2 -> sweep resumes at PRN 4 and next start is PRN 4.
- init_fifo_full=1 during SELECT for 20 cycles -> no acq_start; first start 1 cycle after full drops, at the held PRN.
- Model never raises in_progress -> timeout_err pulses 64 cycles after acq_start, and the next PRN is started.
- Same-cycle completion acquiring PRN 5 and release of PRN 5 -> active_mask[5]=1. With ACQ_SCHED_SWEEP_DELAY_EN and a fruitless sweep -> 1024-cycle gap before the PRN 0 start.

Source files
------------

// File: rtl/acq_scheduler_if.sv
// Handshake between the acquisition sequencer (master) and the acquisition unit (slave).
interface acq_scheduler_if #(
  parameter int PRN_WIDTH = 5
);
  logic                 acq_start;
  logic [PRN_WIDTH-1:0] acq_start_prn;
  logic                 acq_in_progress;
  logic                 acq_complete;
  logic                 satellite_acquired;
  logic [PRN_WIDTH-1:0] acq_prn;

  modport master (
    output acq_start, acq_start_prn,
    input  acq_in_progress, acq_complete, satellite_acquired, acq_prn
  );
  modport slave (
    input  acq_start, acq_start_prn,
    output acq_in_progress, acq_complete, satellite_acquired, acq_prn
  );
endinterface

// File: rtl/acq_scheduler.sv
// Round-robin PRN acquisition sequencer with active-PRN mask and slot/FIFO throttling.
// Define ACQ_SCHED_SWEEP_DELAY_EN to add a BACKOFF pause after each fruitless full sweep.
module acq_scheduler #(
  parameter int NUM_PRN     = 32,
  parameter int PRN_WIDTH   = 5,
  parameter int MAX_SLOTS   = 4,
  parameter int ACK_TIMEOUT = 64,
  parameter int SWEEP_DELAY = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 init_fifo_full,
  input  logic                 release_valid,
  input  logic [PRN_WIDTH-1:0] release_prn,
  acq_scheduler_if.master      acq,
  output logic                 busy,
  output logic [NUM_PRN-1:0]   active_mask,
  output logic [PRN_WIDTH:0]   active_count,
  output logic                 timeout_err
);
  // One timer serves both the ack wait and the sweep backoff.
  localparam int TW = $clog2(ACK_TIMEOUT > SWEEP_DELAY ? ACK_TIMEOUT : SWEEP_DELAY);

  typedef enum logic [2:0] {
    IDLE, SELECT, START, WAIT_ACK, WAIT_DONE
`ifdef ACQ_SCHED_SWEEP_DELAY_EN
    , BACKOFF
`endif
  } state_t;

  state_t               state, state_nxt;
  logic [PRN_WIDTH-1:0] ptr, ptr_inc, start_prn;
  logic [TW-1:0]        timer;
  logic [NUM_PRN-1:0]   mask_nxt;
  logic [PRN_WIDTH:0]   pop;
  logic                 slots_full, cand_active, adv, set_hit, ack_last, timing;

  assign ptr_inc     = (ptr == PRN_WIDTH'(NUM_PRN - 1)) ? '0 : ptr + 1'b1;
  assign cand_active = active_mask[ptr];
  assign set_hit     = acq.acq_complete && acq.satellite_acquired && (acq.acq_prn == start_prn);
  assign ack_last    = (timer == TW'(ACK_TIMEOUT - 1));

  // Slot check uses the live mask so a just-filled last slot blocks the very next SELECT.
  always_comb begin
    pop = '0;
    for (int i = 0; i < NUM_PRN; i++) pop = pop + {{PRN_WIDTH{1'b0}}, active_mask[i]};
  end
  assign slots_full = (pop >= (PRN_WIDTH+1)'(MAX_SLOTS));

  // Release first, then set, so a same-cycle release/acquire of one PRN leaves it active.
  always_comb begin
    mask_nxt = active_mask;
    if (release_valid && ({1'b0, release_prn} < (PRN_WIDTH+1)'(NUM_PRN)))
      mask_nxt[release_prn] = 1'b0;
    if (set_hit) mask_nxt[acq.acq_prn] = 1'b1;
  end

`ifdef ACQ_SCHED_SWEEP_DELAY_EN
  logic wrapped, found, wrap_chk;
  assign wrap_chk = (state == SELECT) && enable && !slots_full && wrapped;
  assign timing   = (state == WAIT_ACK) || (state == BACKOFF);

  always_ff @(posedge clk) begin
    if (reset) begin
      wrapped <= 1'b0;
      found   <= 1'b0;
    end else if (wrap_chk) begin
      wrapped <= 1'b0;
      found   <= set_hit;
    end else begin
      if (adv && ptr == PRN_WIDTH'(NUM_PRN - 1)) wrapped <= 1'b1;
      if (set_hit) found <= 1'b1;
    end
  end
`else
  assign timing = (state == WAIT_ACK);
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (enable && !slots_full) state_nxt = SELECT;
      SELECT:
        if (!enable || slots_full)                  state_nxt = IDLE;
`ifdef ACQ_SCHED_SWEEP_DELAY_EN
        else if (wrapped && !found)                 state_nxt = BACKOFF;
`endif
        else if (!cand_active && !init_fifo_full)   state_nxt = START;
      START:     state_nxt = WAIT_ACK;
      WAIT_ACK:
        if (acq.acq_in_progress && acq.acq_complete) state_nxt = enable ? SELECT : IDLE;
        else if (acq.acq_in_progress)                state_nxt = WAIT_DONE;
        else if (ack_last)                           state_nxt = SELECT;
      WAIT_DONE: if (acq.acq_complete) state_nxt = enable ? SELECT : IDLE;
`ifdef ACQ_SCHED_SWEEP_DELAY_EN
      BACKOFF:
        if (!enable)                                state_nxt = IDLE;
        else if (timer == TW'(SWEEP_DELAY - 1))     state_nxt = SELECT;
`endif
      default:   state_nxt = IDLE;
    endcase
  end

  assign adv = (state == SELECT) &&
               ((state_nxt == START) || (state_nxt == SELECT && cand_active));

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr          <= '0;
      start_prn    <= '0;
      timer        <= '0;
      active_mask  <= '0;
      active_count <= '0;
    end else begin
      active_mask  <= mask_nxt;
      active_count <= pop;
      timer        <= timing ? timer + 1'b1 : '0;
      if (adv) ptr <= ptr_inc;
      if (state == SELECT && state_nxt == START) start_prn <= ptr;
    end
  end

  always_comb begin
    acq.acq_start     = (state == START);
    acq.acq_start_prn = start_prn;
    busy              = (state != IDLE);
    timeout_err       = (state == WAIT_ACK) && !acq.acq_in_progress && ack_last;
  end
endmodule
